// File: rtl/serial_mem_slave_burst.sv
// Bit-serial memory slave: serial address/burst header, then single or burst
// reads/writes against an internal synchronous RAM with address auto-increment.
module serial_mem_slave_burst #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 4096,
  parameter int unsigned BURST_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic read_en,
  input  logic write_en,
  input  logic master_valid,
  input  logic master_ready,
  input  logic rx_address,
  input  logic rx_burst,
  input  logic rx_data,
  output logic slave_ready,
  output logic slave_valid,
  output logic tx_data,
  output logic rx_done,
  output logic slave_tx_done,
  output logic slv_err
);

  localparam int unsigned MAW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, WCOMMIT, RFETCH, RSHIFT, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    rd_mode_q, rd_mode_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_sr_q, addr_sr_d;
  logic [BURST_WIDTH-1:0]  burst_sr_q, burst_sr_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [BURST_WIDTH-1:0]  rem_q, rem_d;
  logic                    err_q, err_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    fetch_q, fetch_d;
  logic [DATA_WIDTH-1:0]   data_sr_q, data_sr_d;
  logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0]   rd_word_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    hdr_take;
  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_WIDTH-1:0]   addr_shift;
  logic [BURST_WIDTH-1:0]  burst_shift;
  logic [BURST_WIDTH-1:0]  burst_final;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [MAW-1:0]          mem_idx;

  assign mem_idx     = cur_addr_q[MAW-1:0];
  assign addr_shift  = (addr_sr_q << 1) | ADDR_WIDTH'(rx_address);
  assign burst_shift = (burst_sr_q << 1) | BURST_WIDTH'(rx_burst);
  assign burst_final = (cnt_q < CW'(BURST_WIDTH)) ? burst_shift : burst_sr_q;
  assign addr_inc    = (cur_addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0
                                                                  : cur_addr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rd_mode_d   = rd_mode_q;
    cnt_d       = cnt_q;
    addr_sr_d   = addr_sr_q;
    burst_sr_d  = burst_sr_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;
    fetch_d     = fetch_q;
    data_sr_d   = data_sr_q;
    tx_sr_d     = tx_sr_q;
    hdr_take    = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;

    case (state_q)
      IDLE: begin
        if (master_valid && (read_en ^ write_en)) begin
          rd_mode_d = read_en;
          hdr_take  = 1'b1;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (master_valid) hdr_take = 1'b1;
      end
      WDATA: begin
        if (master_valid) begin
          data_sr_d = (data_sr_q << 1) | DATA_WIDTH'(rx_data);
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = WCOMMIT;
          end
        end
      end
      WCOMMIT: begin
        mem_we     = !err_q;
        cur_addr_d = addr_inc;
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          rem_d   = rem_q - 1'b1;
          state_d = WDATA;
        end
      end
      RFETCH: begin
        // First cycle issues the RAM read, second loads the registered word.
        if (!fetch_q) begin
          mem_re  = 1'b1;
          fetch_d = 1'b1;
        end else begin
          fetch_d = 1'b0;
          tx_sr_d = err_q ? '0 : rd_word_q;
          cnt_d   = '0;
          state_d = RSHIFT;
        end
      end
      RSHIFT: begin
        if (master_ready) begin
          tx_sr_d = tx_sr_q << 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d      = '0;
            cur_addr_d = addr_inc;
            if (rem_q == '0) begin
              state_d = DONE;
            end else begin
              rem_d   = rem_q - 1'b1;
              state_d = RFETCH;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The start cycle in IDLE carries the first header bit, so both states share this path.
    if (hdr_take) begin
      addr_sr_d = addr_shift;
      if (cnt_q < CW'(BURST_WIDTH)) burst_sr_d = burst_shift;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
        cnt_d       = '0;
        cur_addr_d  = addr_shift;
        rem_d       = burst_final;
        err_d       = ({1'b0, addr_shift} >= (ADDR_WIDTH + 1)'(MEM_DEPTH));
        err_pulse_d = err_d;
        fetch_d     = 1'b0;
        state_d     = rd_mode_d ? RFETCH : WDATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_mode_q   <= 1'b0;
      cnt_q       <= '0;
      addr_sr_q   <= '0;
      burst_sr_q  <= '0;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      fetch_q     <= 1'b0;
      data_sr_q   <= '0;
      tx_sr_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_mode_q   <= rd_mode_d;
      cnt_q       <= cnt_d;
      addr_sr_q   <= addr_sr_d;
      burst_sr_q  <= burst_sr_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      fetch_q     <= fetch_d;
      data_sr_q   <= data_sr_d;
      tx_sr_q     <= tx_sr_d;
    end
  end

  // RAM array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_idx] <= data_sr_q;
    if (mem_re) rd_word_q <= mem[mem_idx];
  end

  assign slave_ready   = !reset && ((state_q == IDLE) || (state_q == HDR) || (state_q == WDATA));
  assign slave_valid   = !reset && (state_q == RSHIFT);
  assign tx_data       = slave_valid && tx_sr_q[DATA_WIDTH-1];
  assign rx_done       = !reset && (state_q == DONE) && !rd_mode_q;
  assign slave_tx_done = !reset && (state_q == DONE) && rd_mode_q;
  assign slv_err       = !reset && err_pulse_q;

endmodule

// File: tb/tb_serial_mem_slave_burst.sv
// Scoreboard bench for serial_mem_slave_burst (12-bit address, 8-bit data, 2048-word RAM).
module tb_serial_mem_slave_burst;

  localparam int EV_ERR   = 1;
  localparam int EV_WDONE = 2;
  localparam int EV_RDONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic read_en = 1'b0, write_en = 1'b0;
  logic master_valid = 1'b0, master_ready = 1'b0;
  logic rx_address = 1'b0, rx_burst = 1'b0, rx_data = 1'b0;
  logic slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, slv_err;

  int tests = 0;
  int fails = 0;
  int ev_q[$];
  logic [7:0] byte_q[$];

  serial_mem_slave_burst #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_DEPTH(2048), .BURST_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
    .master_valid(master_valid), .master_ready(master_ready),
    .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
    .rx_done(rx_done), .slave_tx_done(slave_tx_done), .slv_err(slv_err)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void check_evt(input int code);
    if (ev_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got code %0d, expected none", code);
    end else begin
      check("event_order", code, ev_q.pop_front());
    end
  endfunction

  // Monitor: consumes pulses and serial read data, compares against queued expectations.
  initial begin : monitor
    logic [7:0] sh;
    int nb;
    sh = '0;
    nb = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        nb = 0;
      end else begin
        if (rx_done && slave_tx_done) check("done_exclusive", 1, 0);
        if (slv_err) check_evt(EV_ERR);
        if (rx_done) check_evt(EV_WDONE);
        if (slave_tx_done) check_evt(EV_RDONE);
        if (slave_valid && master_ready) begin
          sh = {sh[6:0], tx_data};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (byte_q.size() == 0) check("unexpected_read_byte", int'(sh), -1);
            else check("read_byte", int'(sh), int'(byte_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic xfer_bit(input logic a, input logic b, input logic d);
    bit ok;
    int g;
    master_valid = 1'b1;
    rx_address = a;
    rx_burst = b;
    rx_data = d;
    ok = 1'b0;
    g = 0;
    while (!ok && g < 100) begin
      @(negedge clk);
      ok = slave_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!ok) check("xfer_timeout", 0, 1);
  endtask

  task automatic idle_cycle();
    master_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic is_read, input logic [11:0] a,
                             input logic [3:0] bl, input bit stall);
    read_en = is_read;
    write_en = !is_read;
    for (int i = 0; i < 12; i++) begin
      xfer_bit(a[11-i], (i < 4) ? bl[3-i] : 1'b0, 1'b0);
      if (stall && (i % 2 == 0)) idle_cycle();
    end
    master_valid = 1'b0;
  endtask

  task automatic wait_pulse_w(input string name);
    bit seen;
    int g;
    seen = 1'b0;
    g = 0;
    while (!seen && g < 200) begin
      @(negedge clk);
      seen = rx_done;
      g++;
    end
    if (!seen) check(name, 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Bytes taken MSB-first from dw; abort_bits >= 0 stops after that many data bits.
  task automatic do_write(input logic [11:0] a, input logic [3:0] bl, input logic [31:0] dw,
                          input bit stall, input int abort_bits);
    logic [7:0] b;
    int nbits;
    if (a >= 12'd2048) ev_q.push_back(EV_ERR);
    if (abort_bits < 0) ev_q.push_back(EV_WDONE);
    send_header(1'b0, a, bl, stall);
    nbits = 0;
    for (int k = 0; k <= int'(bl); k++) begin
      b = dw[31 - 8*k -: 8];
      for (int j = 0; j < 8; j++) begin
        if (abort_bits >= 0 && nbits == abort_bits) return;
        xfer_bit(1'b0, 1'b0, b[7-j]);
        nbits++;
        if (stall && (j % 2 == 0)) idle_cycle();
      end
    end
    master_valid = 1'b0;
    wait_pulse_w("write_done_timeout");
    write_en = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [3:0] bl, input logic [31:0] exp_w,
                         input int stall_after);
    bit done, stalled;
    int seen, g;
    logic held;
    if (a >= 12'd2048) ev_q.push_back(EV_ERR);
    ev_q.push_back(EV_RDONE);
    for (int k = 0; k <= int'(bl); k++) byte_q.push_back(exp_w[31 - 8*k -: 8]);
    send_header(1'b1, a, bl, 1'b0);
    master_ready = 1'b1;
    done = 1'b0;
    stalled = 1'b0;
    seen = 0;
    g = 0;
    while (!done && g < 500) begin
      @(negedge clk);
      g++;
      if (slave_tx_done) done = 1'b1;
      if (slave_valid && master_ready) seen++;
      if (stall_after > 0 && seen == stall_after && !stalled) begin
        stalled = 1'b1;
        @(posedge clk);
        #1 master_ready = 1'b0;
        @(negedge clk);
        held = tx_data;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_valid", int'(slave_valid), 1);
          check("stall_hold", int'(tx_data), int'(held));
        end
        @(posedge clk);
        #1 master_ready = 1'b1;
      end
    end
    if (!done) check("read_done_timeout", 0, 1);
    @(posedge clk);
    #1;
    master_ready = 1'b0;
    read_en = 1'b0;
  endtask

  initial begin : stim
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, slv_err}), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_ready", int'(slave_ready), 1);
    @(posedge clk);
    #1;

    // Single write then read back.
    do_write(12'h010, 4'd0, 32'hA5000000, 1'b0, -1);
    do_read(12'h010, 4'd0, 32'hA5000000, 0);

    // Burst that wraps the top of the 2048-word RAM.
    do_write(12'h7FE, 4'd3, 32'h11223344, 1'b0, -1);
    do_read(12'h7FE, 4'd3, 32'h11223344, 0);
    do_read(12'h000, 4'd0, 32'h33000000, 0);

    // Master-side stalls on write and read.
    do_write(12'h055, 4'd0, 32'h3C000000, 1'b1, -1);
    do_read(12'h055, 4'd0, 32'h3C000000, 3);

    // Out-of-range: 0x900 aliases to index 0x100 in the RAM, which must stay intact.
    do_write(12'h100, 4'd0, 32'hC3000000, 1'b0, -1);
    do_write(12'h900, 4'd0, 32'hFF000000, 1'b0, -1);
    do_read(12'h100, 4'd0, 32'hC3000000, 0);
    do_read(12'h900, 4'd0, 32'h00000000, 0);

    // Illegal start: both enables set.
    read_en = 1'b1;
    write_en = 1'b1;
    master_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("illegal_start_ready", int'(slave_ready), 1);
      @(posedge clk);
      #1;
    end
    master_valid = 1'b0;
    read_en = 1'b0;
    write_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during the second beat of a 4-beat write.
    do_write(12'h021, 4'd0, 32'h77000000, 1'b0, -1);
    do_write(12'h020, 4'd3, 32'h5A99AABB, 1'b0, 11);
    reset = 1'b1;
    master_valid = 1'b0;
    write_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_outputs",
            int'({slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, slv_err}), 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    do_read(12'h020, 4'd1, 32'h5A770000, 0);

    repeat (5) @(posedge clk);
    check("events_pending", ev_q.size(), 0);
    check("bytes_pending", byte_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
